udp_ingress_arb: RTL and testbench

- Frame-level round-robin arbiter. Shares the single udp parser input port (in_din/in_wr_en/in_wr_sof/in_wr_eof/in_full) among NUM_SRC packet sources.
- Each source presents the read side of a byte FIFO carrying sof/eof flags.
- Once granted, a source owns the port until its eof byte is written. No interleaving of frames.
- Sits between per-port capture FIFOs and the udp input FIFO.

---
 rtl/udp_pkg.sv | 14 +
 rtl/rr_pick.sv | 30 +++
 rtl/udp_ingress_arb.sv | 186 ++++++++++++++++++
 tb/tb_udp_ingress_arb.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared types and constants for the udp ingress arbiter
package udp_pkg;

    localparam int BYTE_W        = 8;
    localparam int MAX_SRC       = 8;
    localparam int DEF_MAX_FRAME = 1518;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DRAIN
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick starting at rr_ptr
module rr_pick #(
    parameter int NUM_SRC = 4
) (
    input  logic [2:0]         rr_ptr_i,
    input  logic [NUM_SRC-1:0] req_i,
    output logic [2:0]         sel_o,
    output logic               hit_o
);

    int idx;

    // Walk offsets from the far end so the closest requester to rr_ptr wins last.
    always_comb begin
        sel_o = '0;
        hit_o = 1'b0;
        idx   = 0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_i) + i;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (req_i[idx]) begin
                hit_o = 1'b1;
                sel_o = 3'(idx);
            end
        end
    end

endmodule

// File: rtl/udp_ingress_arb.sv
// rtl/udp_ingress_arb.sv - frame-level round-robin arbiter onto the udp parser input
module udp_ingress_arb
    import udp_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int MAX_FRAME = DEF_MAX_FRAME
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_SRC*BYTE_W-1:0] src_dout,
    input  logic [NUM_SRC-1:0]        src_sof,
    input  logic [NUM_SRC-1:0]        src_eof,
    input  logic [NUM_SRC-1:0]        src_empty,
    output logic [NUM_SRC-1:0]        src_rd_en,
    output logic [BYTE_W-1:0]         in_din,
    output logic                      in_wr_en,
    output logic                      in_wr_sof,
    output logic                      in_wr_eof,
    input  logic                      in_full,
    output logic                      grant_valid,
    output logic [2:0]                grant_idx,
    output logic [31:0]               frame_count,
    output logic [31:0]               drop_count,
    output logic [15:0]               trunc_count
);

    localparam logic [15:0] LAST_IDX = 16'(MAX_FRAME - 1);

    arb_state_t   state_q, state_d;
    logic [2:0]   rr_ptr_q, rr_ptr_d;
    logic [2:0]   grant_idx_q, grant_idx_d;
    logic         grant_valid_q, grant_valid_d;
    logic [15:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0]  frame_cnt_q, frame_cnt_d;
    logic [31:0]  drop_cnt_q, drop_cnt_d;
    logic [15:0]  trunc_cnt_q, trunc_cnt_d;

    logic [2:0]         sel;
    logic               hit;
    logic               sel_sof;
    logic [BYTE_W-1:0]  g_byte;
    logic               g_sof_unused;
    logic               g_eof;
    logic               g_empty;
    logic [2:0]         nxt_ptr;
    logic               at_limit;
    logic [NUM_SRC-1:0] rd_vec;
    logic               wr, wsof, weof;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [2:0] idx);
        logic [NUM_SRC-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (3'(k) == idx) begin
                r[k] = 1'b1;
            end
        end
        return r;
    endfunction

    rr_pick #(.NUM_SRC(NUM_SRC)) u_rr_pick (
        .rr_ptr_i (rr_ptr_q),
        .req_i    (~src_empty),
        .sel_o    (sel),
        .hit_o    (hit)
    );

    always_comb begin
        sel_sof      = 1'b0;
        g_byte       = '0;
        g_sof_unused = 1'b0;
        g_eof        = 1'b0;
        g_empty      = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (3'(k) == sel) begin
                sel_sof = src_sof[k];
            end
            if (3'(k) == grant_idx_q) begin
                g_byte       = src_dout[k*BYTE_W +: BYTE_W];
                g_sof_unused = src_sof[k];
                g_eof        = src_eof[k];
                g_empty      = src_empty[k];
            end
        end
    end

    assign nxt_ptr  = (grant_idx_q == 3'(NUM_SRC - 1)) ? 3'd0 : grant_idx_q + 3'd1;
    assign at_limit = (byte_cnt_q == LAST_IDX);

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;
        byte_cnt_d    = byte_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        trunc_cnt_d   = trunc_cnt_q;
        rd_vec        = '0;
        wr            = 1'b0;
        wsof          = 1'b0;
        weof          = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    if (sel_sof) begin
                        state_d       = XFER;
                        grant_idx_d   = sel;
                        grant_valid_d = 1'b1;
                        byte_cnt_d    = '0;
                    end else begin
                        rd_vec     = onehot(sel);
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end
                end
            end
            XFER: begin
                if (!g_empty && !in_full) begin
                    rd_vec     = onehot(grant_idx_q);
                    wr         = 1'b1;
                    wsof       = (byte_cnt_q == 16'd0);
                    weof       = g_eof || at_limit;
                    byte_cnt_d = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
                    // A natural eof wins over the limit when both land on the same byte.
                    if (g_eof) begin
                        frame_cnt_d   = frame_cnt_q + 32'd1;
                        rr_ptr_d      = nxt_ptr;
                        grant_valid_d = 1'b0;
                        state_d       = IDLE;
                    end else if (at_limit) begin
                        trunc_cnt_d = trunc_cnt_q + 16'd1;
                        rr_ptr_d    = nxt_ptr;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!g_empty) begin
                    rd_vec     = onehot(grant_idx_q);
                    drop_cnt_d = drop_cnt_q + 32'd1;
                    if (g_eof) begin
                        grant_valid_d = 1'b0;
                        state_d       = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
            byte_cnt_q    <= '0;
            frame_cnt_q   <= '0;
            drop_cnt_q    <= '0;
            trunc_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
            byte_cnt_q    <= byte_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            trunc_cnt_q   <= trunc_cnt_d;
        end
    end

    assign src_rd_en   = rd_vec & {NUM_SRC{reset}};
    assign in_wr_en    = wr & reset;
    assign in_wr_sof   = wsof & reset;
    assign in_wr_eof   = weof & reset;
    assign in_din      = g_byte;
    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;
    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;
    assign trunc_count = trunc_cnt_q;

endmodule

// File: tb/tb_udp_ingress_arb.sv
// tb/tb_udp_ingress_arb.sv - bench for udp_ingress_arb with a frame-level reference model
module tb_udp_ingress_arb;

    localparam int NS    = 4;
    localparam int DEPTH = 4096;
    localparam int LOGD  = 8192;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset       [2];
    logic        in_full     [2] = '{1'b0, 1'b0};
    logic [31:0] src_dout    [2];
    logic [3:0]  src_sof     [2];
    logic [3:0]  src_eof     [2];
    logic [3:0]  src_empty   [2];
    logic [3:0]  src_rd_en   [2];
    logic [7:0]  in_din      [2];
    logic        in_wr_en    [2];
    logic        in_wr_sof   [2];
    logic        in_wr_eof   [2];
    logic        grant_valid [2];
    logic [2:0]  grant_idx   [2];
    logic [31:0] frame_count [2];
    logic [31:0] drop_count  [2];
    logic [15:0] trunc_count [2];

    udp_ingress_arb #(.NUM_SRC(NS)) dut0 (
        .clock(clock), .reset(reset[0]), .src_dout(src_dout[0]), .src_sof(src_sof[0]),
        .src_eof(src_eof[0]), .src_empty(src_empty[0]), .src_rd_en(src_rd_en[0]),
        .in_din(in_din[0]), .in_wr_en(in_wr_en[0]), .in_wr_sof(in_wr_sof[0]),
        .in_wr_eof(in_wr_eof[0]), .in_full(in_full[0]), .grant_valid(grant_valid[0]),
        .grant_idx(grant_idx[0]), .frame_count(frame_count[0]), .drop_count(drop_count[0]),
        .trunc_count(trunc_count[0])
    );

    udp_ingress_arb #(.NUM_SRC(NS), .MAX_FRAME(16)) dut1 (
        .clock(clock), .reset(reset[1]), .src_dout(src_dout[1]), .src_sof(src_sof[1]),
        .src_eof(src_eof[1]), .src_empty(src_empty[1]), .src_rd_en(src_rd_en[1]),
        .in_din(in_din[1]), .in_wr_en(in_wr_en[1]), .in_wr_sof(in_wr_sof[1]),
        .in_wr_eof(in_wr_eof[1]), .in_full(in_full[1]), .grant_valid(grant_valid[1]),
        .grant_idx(grant_idx[1]), .frame_count(frame_count[1]), .drop_count(drop_count[1]),
        .trunc_count(trunc_count[1])
    );

    // Source FIFOs: {sof, eof, byte} entries, first-word-fall-through heads.
    logic [9:0] mem [2][NS][DEPTH];
    int         hd  [2][NS] = '{default: 0};
    int         tl  [2][NS];
    logic [3:0] pop_q [2] = '{4'd0, 4'd0};
    int         full_mode [2];
    int         fcyc = 0;

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NS; k++) begin
                src_empty[d][k]      = (hd[d][k] == tl[d][k]);
                src_sof[d][k]        = mem[d][k][hd[d][k]][9];
                src_eof[d][k]        = mem[d][k][hd[d][k]][8];
                src_dout[d][k*8 +: 8] = mem[d][k][hd[d][k]][7:0];
            end
        end
    end

    always @(posedge clock) begin
        fcyc <= fcyc + 1;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < NS; k++) begin
                if (pop_q[d][k] && hd[d][k] != tl[d][k]) hd[d][k] <= hd[d][k] + 1;
            end
            case (full_mode[d])
                1:       in_full[d] <= ((fcyc / 3) % 2) == 1;
                2:       in_full[d] <= ($urandom_range(0, 2) == 0);
                default: in_full[d] <= 1'b0;
            endcase
        end
    end

    logic [9:0] wlog [2][LOGD];
    int         wcnt [2] = '{0, 0};
    int         viol = 0;

    always @(negedge clock) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            if (in_wr_en[d]) begin
                wlog[d][wcnt[d]] = {in_wr_sof[d], in_wr_eof[d], in_din[d]};
                wcnt[d]++;
            end
            if (in_wr_en[d] && in_full[d]) viol++;
            if ($countones(src_rd_en[d]) > 1) viol++;
            if (!reset[d] && (src_rd_en[d] != 4'd0 || in_wr_en[d])) viol++;
            for (int k = 0; k < NS; k++) begin
                if (src_rd_en[d][k] && src_empty[d][k]) viol++;
            end
            pop_q[d] = src_rd_en[d];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [9:0] exp_log [LOGD];
    int exp_n, exp_frames, exp_drops, exp_trunc;

    function automatic int maxf(input int d);
        return (d == 0) ? 1518 : 16;
    endfunction

    task automatic push(input int d, input int k, input logic [9:0] v);
        mem[d][k][tl[d][k]] = v;
        tl[d][k]++;
    endtask

    task automatic load_frame(input int d, input int k, input int len);
        for (int i = 0; i < len; i++) push(d, k, {i == 0, i == len - 1, 8'($urandom)});
    endtask

    task automatic garbage(input int d, input int k, input int n);
        for (int i = 0; i < n; i++) push(d, k, {1'b0, 1'($urandom_range(0, 1)), 8'($urandom)});
    endtask

    // Frame-level view: pick next non-empty source round-robin, drop stray bytes,
    // move whole frames, cut at the limit and discard the rest up to eof.
    task automatic model_run(input int d);
        int mh[NS];
        int ptr, k, n, mx;
        bit found;
        logic [9:0] b;
        mx = maxf(d);
        for (int i = 0; i < NS; i++) mh[i] = hd[d][i];
        exp_n = 0; exp_frames = 0; exp_drops = 0; exp_trunc = 0;
        ptr = 0; k = 0;
        forever begin
            found = 0;
            for (int i = 0; i < NS && !found; i++) begin
                k = (ptr + i) % NS;
                if (mh[k] != tl[d][k]) found = 1;
            end
            if (!found) break;
            b = mem[d][k][mh[k]];
            if (!b[9]) begin
                exp_drops++;
                mh[k]++;
                continue;
            end
            n = 0;
            forever begin
                b = mem[d][k][mh[k]];
                mh[k]++;
                exp_log[exp_n] = {n == 0, b[8] || n == mx - 1, b[7:0]};
                exp_n++;
                n++;
                if (b[8]) begin
                    exp_frames++;
                    break;
                end
                if (n == mx) begin
                    exp_trunc++;
                    do begin
                        b = mem[d][k][mh[k]];
                        mh[k]++;
                        exp_drops++;
                    end while (!b[8]);
                    break;
                end
            end
            ptr = (k + 1) % NS;
        end
    endtask

    task automatic begin_scn(input int d, input int mode);
        reset[d] = 1'b0;
        full_mode[d] = mode;
        repeat (2) @(negedge clock);
        check("rst_grant_valid", 32'(grant_valid[d]), 0);
        check("rst_counters", frame_count[d] | drop_count[d] | 32'(trunc_count[d]), 0);
    endtask

    task automatic run_wait(input int d);
        bit done = 0;
        bit all_empty;
        for (int i = 0; i < 6000 && !done; i++) begin
            @(negedge clock);
            all_empty = 1;
            for (int k = 0; k < NS; k++) if (hd[d][k] != tl[d][k]) all_empty = 0;
            if (all_empty && !grant_valid[d]) done = 1;
        end
        if (!done) check("timeout", 0, 1);
        repeat (3) @(negedge clock);
    endtask

    task automatic compare(input int d, input string tag, input int base);
        int n, e0;
        n = wcnt[d] - base;
        check({tag, "_nbytes"}, n, exp_n);
        for (int i = 0; i < n && i < exp_n; i++) begin
            e0 = n_errors;
            check({tag, "_byte"}, 32'(wlog[d][base + i]), 32'(exp_log[i]));
            if (n_errors != e0) break;
        end
        check({tag, "_frames"}, frame_count[d], exp_frames);
        check({tag, "_drops"}, drop_count[d], exp_drops);
        check({tag, "_trunc"}, 32'(trunc_count[d]), exp_trunc);
        check({tag, "_idle"}, 32'(grant_valid[d]), 0);
    endtask

    task automatic go(input int d, input string tag);
        int base;
        model_run(d);
        base = wcnt[d];
        reset[d] = 1'b1;
        run_wait(d);
        compare(d, tag, base);
    endtask

    initial begin
        int base, base2, lat;
        reset[0] = 1'b0; reset[1] = 1'b0;
        full_mode[0] = 0; full_mode[1] = 0;
        for (int d = 0; d < 2; d++) for (int k = 0; k < NS; k++) tl[d][k] = 0;

        // single 60-byte frame, with first-write latency
        begin_scn(0, 0);
        load_frame(0, 0, 60);
        model_run(0);
        base = wcnt[0];
        @(negedge clock);
        reset[0] = 1'b1;
        lat = -1;
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            @(negedge clock);
            #1;
            if (in_wr_en[0]) lat = i;
        end
        check("first_wr_latency", lat, 1);
        run_wait(0);
        compare(0, "single60", base);
        check("single60_frames_const", frame_count[0], 1);

        // two sources, three frames each
        begin_scn(0, 0);
        for (int f = 0; f < 3; f++) begin
            load_frame(0, 0, 64);
            load_frame(0, 2, 64);
        end
        go(0, "rr_0_2");
        check("rr_frames_const", frame_count[0], 6);

        // backpressure toggling every 3 cycles
        begin_scn(0, 1);
        load_frame(0, 1, 100);
        go(0, "full_toggle");

        // stray bytes before a frame
        begin_scn(0, 0);
        garbage(0, 1, 5);
        load_frame(0, 1, 20);
        go(0, "nosof");
        check("nosof_drops_const", drop_count[0], 5);

        // truncation at MAX_FRAME=16
        begin_scn(1, 0);
        load_frame(1, 3, 25);
        go(1, "trunc");
        check("trunc_count_const", 32'(trunc_count[1]), 1);
        check("trunc_drops_const", drop_count[1], 9);

        // reset mid-frame
        begin_scn(0, 0);
        load_frame(0, 1, 30);
        base = wcnt[0];
        reset[0] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            #3;
            if (wcnt[0] - base >= 10) break;
        end
        @(negedge clock);
        reset[0] = 1'b0;
        #1;
        check("rst_rd_en_low", 32'(src_rd_en[0]), 0);
        check("rst_wr_en_low", 32'(in_wr_en[0]), 0);
        @(negedge clock);
        check("midrst_counters", frame_count[0] | drop_count[0] | 32'(trunc_count[0]), 0);
        check("midrst_grant_valid", 32'(grant_valid[0]), 0);
        model_run(0);
        base2 = wcnt[0];
        check("midrst_pre_bytes", base2 - base, 10);
        reset[0] = 1'b1;
        run_wait(0);
        compare(0, "midrst", base2);
        check("midrst_drops_const", drop_count[0], 20);

        // randomized multi-source traffic on both limits
        for (int d = 0; d < 2; d++) begin
            for (int it = 0; it < 4; it++) begin
                begin_scn(d, $urandom_range(0, 2));
                for (int k = 0; k < NS; k++) begin
                    int nf;
                    nf = $urandom_range(0, 3);
                    for (int f = 0; f < nf; f++) begin
                        garbage(d, k, $urandom_range(0, 2));
                        load_frame(d, k, $urandom_range(1, 40));
                    end
                end
                go(d, "random");
            end
        end

        check("protocol_violations", viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
